plpbot_uart_bridge: RTL

//  Serial-to-bus initiator: host PC drives the PLPbot data bus over RS232 (8N1) for bring-up/debug.

---
 rtl/plpbot_bridge_pkg.sv | 29 ++
 rtl/plpbot_bridge_serial.sv | 157 +++++++++++++++
 rtl/plpbot_uart_bridge.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/plpbot_bridge_pkg.sv
// Shared constants and state encodings for the PLPbot serial-to-bus bridge.
package plpbot_bridge_pkg;

    localparam logic [7:0] CMD_WRITE = 8'h57;
    localparam logic [7:0] CMD_READ  = 8'h52;
    localparam logic [7:0] RSP_ACK   = 8'h06;
    localparam logic [7:0] RSP_NAK   = 8'h15;

    localparam logic [1:0] DRW_IDLE  = 2'b00;
    localparam logic [1:0] DRW_WRITE = 2'b01;
    localparam logic [1:0] DRW_READ  = 2'b10;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CMD,
        ST_ADDR,
        ST_DATA,
        ST_BUS,
        ST_REPLY
    } bridge_state_t;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP
    } rx_state_t;

endpackage

// File: rtl/plpbot_bridge_serial.sv
// 8N1 serial front end: 16x oversampled receiver, back-to-back capable transmitter,
// and the shared oversample tick.
module plpbot_bridge_serial
    import plpbot_bridge_pkg::*;
#(
    parameter int OVS_DIV = 162
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rxd,
    output logic       tick,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       rx_ferr,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       tx_idle,
    output logic       txd
);

    localparam int DIV_W    = (OVS_DIV > 1) ? $clog2(OVS_DIV) : 1;
    localparam int BIT_CLKS = 16 * OVS_DIV;
    localparam int BIT_W    = $clog2(BIT_CLKS);

    logic [DIV_W-1:0] div_cnt;
    logic             rxd_meta;
    logic             rxd_sync;
    logic             rxd_prev;
    rx_state_t        rx_state;
    logic [3:0]       rx_tick;
    logic [2:0]       rx_bit;
    logic [7:0]       rx_shift;
    logic             tx_active;
    logic [9:0]       tx_shift;
    logic [3:0]       tx_bit;
    logic [BIT_W-1:0] tx_cnt;
    logic             tx_bit_end;
    logic             tx_last;

    assign tick = (div_cnt == DIV_W'(OVS_DIV - 1));

    always_ff @(posedge clk) begin
        if (rst || tick) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + DIV_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rxd_meta <= 1'b1;
            rxd_sync <= 1'b1;
            rxd_prev <= 1'b1;
        end else begin
            rxd_meta <= rxd;
            rxd_sync <= rxd_meta;
            rxd_prev <= rxd_sync;
        end
    end

    // Start edge is re-checked 8 ticks later; every later sample lands 16 ticks on, at mid-bit.
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_state <= RX_IDLE;
            rx_tick  <= '0;
            rx_bit   <= '0;
            rx_shift <= '0;
            rx_data  <= '0;
            rx_valid <= 1'b0;
            rx_ferr  <= 1'b0;
        end else begin
            rx_valid <= 1'b0;
            rx_ferr  <= 1'b0;
            case (rx_state)
                RX_IDLE: begin
                    if (rxd_prev && !rxd_sync) begin
                        rx_state <= RX_START;
                        rx_tick  <= '0;
                    end
                end
                RX_START: begin
                    if (tick) begin
                        if (rx_tick == 4'd7) begin
                            rx_tick  <= '0;
                            rx_bit   <= '0;
                            rx_state <= rxd_sync ? RX_IDLE : RX_DATA;
                        end else begin
                            rx_tick <= rx_tick + 4'd1;
                        end
                    end
                end
                RX_DATA: begin
                    if (tick) begin
                        rx_tick <= rx_tick + 4'd1;
                        if (rx_tick == 4'd15) begin
                            rx_shift <= {rxd_sync, rx_shift[7:1]};
                            rx_bit   <= rx_bit + 3'd1;
                            if (rx_bit == 3'd7) begin
                                rx_state <= RX_STOP;
                            end
                        end
                    end
                end
                RX_STOP: begin
                    if (tick) begin
                        rx_tick <= rx_tick + 4'd1;
                        if (rx_tick == 4'd15) begin
                            rx_state <= RX_IDLE;
                            if (rxd_sync) begin
                                rx_valid <= 1'b1;
                                rx_data  <= rx_shift;
                            end else begin
                                rx_ferr <= 1'b1;
                            end
                        end
                    end
                end
                default: rx_state <= RX_IDLE;
            endcase
        end
    end

    assign tx_bit_end = (tx_cnt == BIT_W'(BIT_CLKS - 1));
    assign tx_last    = tx_active && tx_bit_end && (tx_bit == 4'd9);
    assign tx_ready   = !tx_active || tx_last;
    assign tx_idle    = !tx_active;
    assign txd        = tx_shift[0];

    // A byte offered while the stop bit finishes is loaded on that same edge: no idle gap.
    always_ff @(posedge clk) begin
        if (rst) begin
            tx_active <= 1'b0;
            tx_shift  <= '1;
            tx_bit    <= '0;
            tx_cnt    <= '0;
        end else if (tx_valid && tx_ready) begin
            tx_active <= 1'b1;
            tx_shift  <= {1'b1, tx_data, 1'b0};
            tx_bit    <= '0;
            tx_cnt    <= '0;
        end else if (tx_active) begin
            if (tx_bit_end) begin
                tx_cnt   <= '0;
                tx_shift <= {1'b1, tx_shift[9:1]};
                tx_bit   <= tx_bit + 4'd1;
                if (tx_bit == 4'd9) begin
                    tx_active <= 1'b0;
                end
            end else begin
                tx_cnt <= tx_cnt + BIT_W'(1);
            end
        end
    end

endmodule

// File: rtl/plpbot_uart_bridge.sv
// Host-driven bus initiator: parses 'W'/'R' frames from rxd, runs one bus cycle, replies on txd.
// Optional inter-byte frame timeout is built when PLPBOT_BRIDGE_TIMEOUT_EN is defined.
module plpbot_uart_bridge
    import plpbot_bridge_pkg::*;
#(
    parameter int CLK_HZ       = 25000000,
    parameter int BAUD         = 9600,
    parameter int TIMEOUT_BITS = 40
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rxd,
    output logic        txd,
    output logic        m_de,
    output logic [1:0]  m_drw,
    output logic [31:0] m_daddr,
    output logic [31:0] m_dout,
    input  logic [31:0] m_din,
    output logic        busy,
    output logic        err_frame,
    output logic        err_overrun
);

    localparam int OVS_DIV = CLK_HZ / (16 * BAUD);

    bridge_state_t state;
    bridge_state_t state_next;
    logic          tick;
    logic [7:0]    rx_data;
    logic          rx_valid;
    logic          rx_ferr;
    logic [7:0]    tx_data;
    logic          tx_valid;
    logic          tx_ready;
    logic          tx_idle;
    logic [7:0]    cmd_byte;
    logic          is_write;
    logic          cmd_ok;
    logic [1:0]    field_cnt;
    logic [31:0]   addr_buf;
    logic [31:0]   data_buf;
    logic [31:0]   reply_sh;
    logic [2:0]    reply_left;
    logic          timeout_hit;

    plpbot_bridge_serial #(
        .OVS_DIV (OVS_DIV)
    ) u_serial (
        .clk      (clk),
        .rst      (rst),
        .rxd      (rxd),
        .tick     (tick),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .rx_ferr  (rx_ferr),
        .tx_data  (tx_data),
        .tx_valid (tx_valid),
        .tx_ready (tx_ready),
        .tx_idle  (tx_idle),
        .txd      (txd)
    );

    assign is_write = (cmd_byte == CMD_WRITE);
    assign cmd_ok   = is_write || (cmd_byte == CMD_READ);

`ifdef PLPBOT_BRIDGE_TIMEOUT_EN
    localparam logic [15:0] TO_TICKS = 16'(TIMEOUT_BITS * 16);
    logic [15:0] to_cnt;
    logic        parsing;

    assign parsing     = (state == ST_CMD) || (state == ST_ADDR) || (state == ST_DATA);
    assign timeout_hit = parsing && tick && (to_cnt == TO_TICKS - 16'd1);

    always_ff @(posedge clk) begin
        if (rst || !parsing || rx_valid) begin
            to_cnt <= '0;
        end else if (tick) begin
            to_cnt <= to_cnt + 16'd1;
        end
    end
`else
    logic unused_cfg;
    assign timeout_hit = 1'b0;
    assign unused_cfg  = &{1'b0, tick, TIMEOUT_BITS[0]};
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Any abort inside a partial frame (bad stop bit or timeout) falls straight to a NAK reply.
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:  if (rx_valid) state_next = ST_CMD;
            ST_CMD:   state_next = cmd_ok ? ST_ADDR : ST_REPLY;
            ST_ADDR: begin
                if (rx_ferr || timeout_hit) begin
                    state_next = ST_REPLY;
                end else if (rx_valid && field_cnt == 2'd3) begin
                    state_next = is_write ? ST_DATA : ST_BUS;
                end
            end
            ST_DATA: begin
                if (rx_ferr || timeout_hit) begin
                    state_next = ST_REPLY;
                end else if (rx_valid && field_cnt == 2'd3) begin
                    state_next = ST_BUS;
                end
            end
            ST_BUS:   state_next = ST_REPLY;
            ST_REPLY: if (reply_left == 3'd0 && tx_idle) state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        m_de     = 1'b0;
        m_drw    = DRW_IDLE;
        busy     = (state != ST_IDLE);
        tx_valid = (state == ST_REPLY) && (reply_left != 3'd0);
        tx_data  = reply_sh[31:24];
        if (state == ST_BUS) begin
            m_de  = 1'b1;
            m_drw = is_write ? DRW_WRITE : DRW_READ;
        end
    end

    // Bus address/data only change on the edge into the bus cycle, so they hold otherwise.
    always_ff @(posedge clk) begin
        if (rst) begin
            cmd_byte   <= '0;
            field_cnt  <= '0;
            addr_buf   <= '0;
            data_buf   <= '0;
            reply_sh   <= '0;
            reply_left <= '0;
            m_daddr    <= '0;
            m_dout     <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (rx_valid) cmd_byte <= rx_data;
                end
                ST_CMD: begin
                    field_cnt <= '0;
                    if (!cmd_ok) begin
                        reply_sh   <= {RSP_NAK, 24'h0};
                        reply_left <= 3'd1;
                    end
                end
                ST_ADDR: begin
                    if (rx_ferr || timeout_hit) begin
                        reply_sh   <= {RSP_NAK, 24'h0};
                        reply_left <= 3'd1;
                    end else if (rx_valid) begin
                        addr_buf  <= {addr_buf[23:0], rx_data};
                        field_cnt <= field_cnt + 2'd1;
                        if (field_cnt == 2'd3 && !is_write) begin
                            m_daddr <= {addr_buf[23:0], rx_data};
                        end
                    end
                end
                ST_DATA: begin
                    if (rx_ferr || timeout_hit) begin
                        reply_sh   <= {RSP_NAK, 24'h0};
                        reply_left <= 3'd1;
                    end else if (rx_valid) begin
                        data_buf  <= {data_buf[23:0], rx_data};
                        field_cnt <= field_cnt + 2'd1;
                        if (field_cnt == 2'd3) begin
                            m_daddr <= addr_buf;
                            m_dout  <= {data_buf[23:0], rx_data};
                        end
                    end
                end
                ST_BUS: begin
                    if (is_write) begin
                        reply_sh   <= {RSP_ACK, 24'h0};
                        reply_left <= 3'd1;
                    end else begin
                        reply_sh   <= m_din;
                        reply_left <= 3'd4;
                    end
                end
                ST_REPLY: begin
                    if (tx_valid && tx_ready) begin
                        reply_sh   <= {reply_sh[23:0], 8'h00};
                        reply_left <= reply_left - 3'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            err_frame   <= 1'b0;
            err_overrun <= 1'b0;
        end else begin
            if (rx_ferr) err_frame <= 1'b1;
            if (rx_valid && (state == ST_BUS || state == ST_REPLY)) err_overrun <= 1'b1;
        end
    end

endmodule
